output_deskewer: RTL and testbench

- Realigns the diagonally skewed result wavefront leaving the systolic array's output edge into row-parallel words.
- Lane i leaves the array i cycles after lane 0 of the same row. This block delays lane i by (MATRIX_SIZE-1-i) enabled cycles so that all lanes of a row appear on the same cycle.
- Tracks row validity and row position, so the result writer sees a clean valid/last stream.
- Sits between the array output edge and the result writeback path, stalling in lockstep with the array via enable_in.

---
 rtl/output_deskewer.sv | 94 +++++++++
 tb/tb_output_deskewer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/output_deskewer.sv
// Realigns the diagonally skewed output wavefront of the systolic array into row-parallel words,
// with a valid/last/row-index stream for the result writer.
module output_deskewer #(
    parameter int unsigned MATRIX_SIZE = 2,
    parameter int unsigned DATA_SIZE   = 32
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    input  logic                                                    enable_in,
    input  logic                                                    valid_in,
    input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]                   data_skewed,
    output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]                   data_out,
    output logic                                                    valid_out,
    output logic                                                    last_out,
    output logic [((MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1)-1:0] row_idx
);

    localparam int unsigned CntW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    logic            vtail;
    logic [CntW-1:0] row_cnt_q, row_cnt_d;
    logic            row_is_last;

    // Lane i trails lane 0 by i cycles, so it needs MATRIX_SIZE-1-i stages to line up.
    for (genvar i = 0; i < int'(MATRIX_SIZE); i++) begin : g_lane
        localparam int Depth = int'(MATRIX_SIZE) - 1 - i;

        if (Depth == 0) begin : g_pass
            assign data_out[i] = data_skewed[i];
        end else begin : g_pipe
            logic [DATA_SIZE-1:0] pipe_q [Depth];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < Depth; k++) begin
                        pipe_q[k] <= '0;
                    end
                end else if (enable_in) begin
                    pipe_q[0] <= data_skewed[i];
                    for (int k = 1; k < Depth; k++) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end

            assign data_out[i] = pipe_q[Depth-1];
        end
    end

    if (MATRIX_SIZE > 1) begin : g_vpipe
        logic [MATRIX_SIZE-2:0] vpipe_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vpipe_q <= '0;
            end else if (enable_in) begin
                vpipe_q[0] <= valid_in;
                for (int k = 1; k < int'(MATRIX_SIZE) - 1; k++) begin
                    vpipe_q[k] <= vpipe_q[k-1];
                end
            end
        end

        assign vtail = vpipe_q[MATRIX_SIZE-2];
    end else begin : g_vpass
        assign vtail = valid_in;
    end

    // Gating with enable_in keeps a stalled row from being presented (and counted) twice.
    assign valid_out   = vtail & enable_in;
    assign row_is_last = (row_cnt_q == CntW'(MATRIX_SIZE - 1));
    assign last_out    = valid_out & row_is_last;
    assign row_idx     = row_cnt_q;

    always_comb begin
        row_cnt_d = row_cnt_q;
        if (valid_out) begin
            if (row_is_last) begin
                row_cnt_d = '0;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt_q <= '0;
        end else begin
            row_cnt_q <= row_cnt_d;
        end
    end

endmodule

// File: tb/tb_output_deskewer.sv
// Directed bench for output_deskewer: a 3-lane instance for the main scenarios and a 1-lane
// instance for the degenerate case.
module tb_output_deskewer;

    logic clk = 1'b0;
    logic reset;

    logic            en3, vin3;
    logic [2:0][31:0] din3, dout3;
    logic            vout3, last3;
    logic [1:0]      idx3;

    logic            en1, vin1;
    logic [0:0][7:0] din1, dout1;
    logic            vout1, last1;
    logic [0:0]      idx1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    output_deskewer #(.MATRIX_SIZE(3), .DATA_SIZE(32)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .enable_in   (en3),
        .valid_in    (vin3),
        .data_skewed (din3),
        .data_out    (dout3),
        .valid_out   (vout3),
        .last_out    (last3),
        .row_idx     (idx3)
    );

    output_deskewer #(.MATRIX_SIZE(1), .DATA_SIZE(8)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable_in   (en1),
        .valid_in    (vin1),
        .data_skewed (din1),
        .data_out    (dout1),
        .valid_out   (vout1),
        .last_out    (last1),
        .row_idx     (idx1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // One cycle on the 3-lane DUT: drive at posedge+1, check at the following negedge.
    task automatic vec3(input string tag, input logic en, input logic vin,
                        input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                        input logic ev, input logic el, input logic [1:0] eidx,
                        input logic chk, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2);
        en3     = en;
        vin3    = vin;
        din3[0] = l0;
        din3[1] = l1;
        din3[2] = l2;
        @(negedge clk);
        check_eq({tag, ".valid"}, 64'(vout3), 64'(ev));
        check_eq({tag, ".last"},  64'(last3), 64'(el));
        check_eq({tag, ".idx"},   64'(idx3),  64'(eidx));
        if (chk) begin
            check_eq({tag, ".lane0"}, 64'(dout3[0]), 64'(e0));
            check_eq({tag, ".lane1"}, 64'(dout3[1]), 64'(e1));
            check_eq({tag, ".lane2"}, 64'(dout3[2]), 64'(e2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic vec1(input string tag, input logic en, input logic vin, input logic [7:0] d,
                        input logic ev);
        en1     = en;
        vin1    = vin;
        din1[0] = d;
        @(negedge clk);
        check_eq({tag, ".data"},  64'(dout1[0]), 64'(d));
        check_eq({tag, ".valid"}, 64'(vout1),    64'(ev));
        check_eq({tag, ".last"},  64'(last1),    64'(ev));
        check_eq({tag, ".idx"},   64'(idx1),     64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input logic en);
        reset = 1'b1;
        en3   = en;
        vin3  = 1'b0;
        din3  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        en3 = 1'b0; vin3 = 1'b0; din3 = '0;
        en1 = 1'b0; vin1 = 1'b0; din1 = '0;
        @(posedge clk);
        #1;
        pulse_reset(1'b1);

        // Reset state: registered lanes zero, last lane follows its input.
        vec3("rst", 0, 0, 32'hAA, 32'hBB, 32'h5A, 0, 0, 0, 1, 32'h0, 32'h0, 32'h5A);

        // 1. Basic deskew
        vec3("t1c0", 1, 1, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t1c1", 1, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t1c2", 1, 1, 32'h20, 32'h11, 32'h02, 1, 0, 0, 1, 32'h00, 32'h01, 32'h02);
        vec3("t1c3", 1, 0, 32'h00, 32'h21, 32'h12, 1, 0, 1, 1, 32'h10, 32'h11, 32'h12);
        vec3("t1c4", 1, 0, 32'h00, 32'h00, 32'h22, 1, 1, 2, 1, 32'h20, 32'h21, 32'h22);
        vec3("t1c5", 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);

        // 2. Mid-tile stall of two cycles with inputs held
        vec3("t2c0", 1, 1, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t2c1", 1, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t2s1", 0, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 1, 32'h00, 32'h01, 32'h00);
        vec3("t2s2", 0, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 1, 32'h00, 32'h01, 32'h00);
        vec3("t2c2", 1, 1, 32'h20, 32'h11, 32'h02, 1, 0, 0, 1, 32'h00, 32'h01, 32'h02);
        vec3("t2c3", 1, 0, 32'h00, 32'h21, 32'h12, 1, 0, 1, 1, 32'h10, 32'h11, 32'h12);
        vec3("t2c4", 1, 0, 32'h00, 32'h00, 32'h22, 1, 1, 2, 1, 32'h20, 32'h21, 32'h22);
        vec3("t2c5", 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);

        // 3. Back-to-back tiles, six rows
        vec3("t3c0", 1, 1, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t3c1", 1, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t3c2", 1, 1, 32'h20, 32'h11, 32'h02, 1, 0, 0, 1, 32'h00, 32'h01, 32'h02);
        vec3("t3c3", 1, 1, 32'h30, 32'h21, 32'h12, 1, 0, 1, 1, 32'h10, 32'h11, 32'h12);
        vec3("t3c4", 1, 1, 32'h40, 32'h31, 32'h22, 1, 1, 2, 1, 32'h20, 32'h21, 32'h22);
        vec3("t3c5", 1, 1, 32'h50, 32'h41, 32'h32, 1, 0, 0, 1, 32'h30, 32'h31, 32'h32);
        vec3("t3c6", 1, 0, 32'h00, 32'h51, 32'h42, 1, 0, 1, 1, 32'h40, 32'h41, 32'h42);
        vec3("t3c7", 1, 0, 32'h00, 32'h00, 32'h52, 1, 1, 2, 1, 32'h50, 32'h51, 32'h52);
        vec3("t3c8", 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);

        // 4. Reset mid-tile (enable low during reset: reset must still win)
        vec3("t4c0", 1, 1, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t4c1", 1, 1, 32'h10, 32'h01, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        pulse_reset(1'b0);
        vec3("t4r0", 1, 1, 32'h80, 32'h00, 32'h00, 0, 0, 0, 1, 32'h00, 32'h00, 32'h00);
        vec3("t4r1", 1, 1, 32'h90, 32'h81, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t4r2", 1, 1, 32'hA0, 32'h91, 32'h82, 1, 0, 0, 1, 32'h80, 32'h81, 32'h82);
        vec3("t4r3", 1, 0, 32'h00, 32'hA1, 32'h92, 1, 0, 1, 1, 32'h90, 32'h91, 32'h92);
        vec3("t4r4", 1, 0, 32'h00, 32'h00, 32'hA2, 1, 1, 2, 1, 32'hA0, 32'hA1, 32'hA2);
        vec3("t4r5", 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);

        // 5. Gapped input 1,0,1,1
        vec3("t5c0", 1, 1, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t5c1", 1, 0, 32'h00, 32'h01, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        vec3("t5c2", 1, 1, 32'h20, 32'h00, 32'h02, 1, 0, 0, 1, 32'h00, 32'h01, 32'h02);
        vec3("t5c3", 1, 1, 32'h30, 32'h21, 32'h00, 0, 0, 1, 0, 0, 0, 0);
        vec3("t5c4", 1, 0, 32'h00, 32'h31, 32'h22, 1, 0, 1, 1, 32'h20, 32'h21, 32'h22);
        vec3("t5c5", 1, 0, 32'h00, 32'h00, 32'h32, 1, 1, 2, 1, 32'h30, 32'h31, 32'h32);
        vec3("t5c6", 1, 0, 32'h00, 32'h00, 32'h00, 0, 0, 0, 0, 0, 0, 0);

        // 6. Degenerate single-lane instance
        en3 = 1'b0;
        vin3 = 1'b0;
        vec1("t6a", 1, 1, 8'h3C, 1);
        vec1("t6b", 0, 1, 8'hA5, 0);
        vec1("t6c", 1, 0, 8'h5A, 0);
        vec1("t6d", 1, 1, 8'hFF, 1);
        vec1("t6e", 1, 1, 8'h81, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
